// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the fetch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [5:0] C_HALT_OP_DEFAULT = 6'h3F;
    localparam int         C_OP_MSB          = 31;
    localparam int         C_OP_LSB          = 26;

endpackage

`default_nettype wire

// File: rtl/fetch_seq_if.sv
// ============================================================================
// Module : fetch_seq_if
// Brief  : Instruction-memory, redirect and dispatch signals of fetch_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_seq_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               deq_valid;
    logic               deq_ready;
    logic [31:0]        deq_inst;
    logic [ADDR_W-1:0]  deq_pc;
    logic [C_CNT_W-1:0] count;
    logic               halted;

    // master: the sequencer; slave: memory + dispatch side
    modport master (
        output imem_addr, deq_valid, deq_inst, deq_pc, count, halted,
        input  imem_rdata, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_addr, deq_valid, deq_inst, deq_pc, count, halted,
        output imem_rdata, redirect_valid, redirect_pc, deq_ready
    );

endinterface

`default_nettype wire

// File: rtl/inst_fifo.sv
// ============================================================================
// Module : inst_fifo
// Brief  : Synchronous FIFO of {inst, pc} entries with clear and comb head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fifo #(
    parameter  int DEPTH   = 4,
    parameter  int ADDR_W  = 10,
    localparam int C_PTR_W = $clog2(DEPTH),
    localparam int C_CNT_W = C_PTR_W + 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_push,
    input  wire logic               i_pop,
    input  wire logic               i_clear,
    input  wire logic [31:0]        i_inst,
    input  wire logic [ADDR_W-1:0]  i_pc,
    output logic      [C_CNT_W-1:0] o_count,
    output logic      [31:0]        o_head_inst,
    output logic      [ADDR_W-1:0]  o_head_pc
);

    logic [31:0]       r_inst [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [C_CNT_W-1:0] r_wptr;
    logic [C_CNT_W-1:0] r_rptr;
    logic               w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // A push into a full FIFO with a same-cycle pop reuses the slot being vacated
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_inst[r_wptr[C_PTR_W-1:0]] <= i_inst;
            r_pc[r_wptr[C_PTR_W-1:0]]   <= i_pc;
        end
    end

    assign w_empty     = (r_wptr == r_rptr);
    assign o_count     = r_wptr - r_rptr;
    assign o_head_inst = w_empty ? '0 : r_inst[r_rptr[C_PTR_W-1:0]];
    assign o_head_pc   = w_empty ? '0 : r_pc[r_rptr[C_PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/fetch_seq.sv
// ============================================================================
// Module : fetch_seq
// Brief  : PC owner, fetch FSM and redirect handling in front of dispatch.
//          Optional perf counters with FETCH_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_seq
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter logic [5:0]        HALT_OP  = C_HALT_OP_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_seq_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int                 C_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [C_CNT_W-1:0] w_count;
    logic               w_deq;
    logic               w_enq;
    logic               w_is_halt;

    assign w_deq     = bus.deq_valid && bus.deq_ready;
    assign w_enq     = (r_state == ST_RUN) && !bus.redirect_valid &&
                       ((w_count < C_FULL) || w_deq);
    assign w_is_halt = (bus.imem_rdata[C_OP_MSB:C_OP_LSB] == HALT_OP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= START_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Redirect overrides everything, including HALT and BOOT
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (bus.redirect_valid) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = bus.redirect_pc;
        end else begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_enq) begin
                        w_pc_nxt = r_pc + 1'b1;
                        if (w_is_halt) w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT: w_state_nxt = ST_HALT;
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    inst_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_enq),
        .i_pop       (w_deq),
        .i_clear     (bus.redirect_valid),
        .i_inst      (bus.imem_rdata),
        .i_pc        (r_pc),
        .o_count     (w_count),
        .o_head_inst (bus.deq_inst),
        .o_head_pc   (bus.deq_pc)
    );

    assign bus.imem_addr = r_pc;
    assign bus.deq_valid = (w_count != '0);
    assign bus.count     = w_count;
    assign bus.halted    = (r_state == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_enq) r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((r_state == ST_RUN) && (w_count == C_FULL) && !w_deq)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// ============================================================================
// Module : tb_fetch_seq
// Brief  : Directed + random stimulus against a queue-based fetch model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_seq;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int MEMSZ  = 1 << ADDR_W;

    typedef struct {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_seq_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_seq #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .START_PC (10'd0),
        .HALT_OP  (6'h3F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    logic [31:0] imem [MEMSZ];
    assign bus.imem_rdata = imem[bus.imem_addr];

    // Reference model: a queue of fetched words plus PC/boot/halt flags
    ent_t q[$];
    int   mpc;
    bit   m_boot;
    bit   m_halt;
    int   checks;
    int   errors;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc    = 0;
        m_boot = 1'b1;
        m_halt = 1'b0;
    endtask

    task automatic model_step(input bit rdy, input bit redir, input int rpc);
        int sz;
        bit deq;
        sz  = q.size();
        deq = (sz > 0) && rdy;
        if (redir) begin
            q.delete();
            mpc    = rpc;
            m_boot = 1'b0;
            m_halt = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            if (deq) void'(q.pop_front());
            if (!m_halt && (sz < DEPTH || deq)) begin
                q.push_back('{imem[mpc], ADDR_W'(mpc)});
                if (imem[mpc][31:26] == 6'h3F) m_halt = 1'b1;
                mpc = (mpc + 1) % MEMSZ;
            end
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = '{32'd0, '0};
        if (q.size() > 0) h = q[0];
        chk("count",     32'(bus.count),     32'(q.size()));
        chk("deq_valid", 32'(bus.deq_valid), 32'(q.size() > 0));
        chk("deq_inst",  bus.deq_inst,       h.inst);
        chk("deq_pc",    32'(bus.deq_pc),    32'(h.pc));
        chk("imem_addr", 32'(bus.imem_addr), 32'(mpc));
        chk("halted",    32'(bus.halted),    32'(m_halt));
    endtask

    // One clock: drive inputs, step the model at the edge, check at negedge
    task automatic cyc(input bit rdy, input bit redir, input int rpc);
        bus.deq_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = ADDR_W'(rpc);
        @(posedge clk);
        model_step(rdy, redir, rpc);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < MEMSZ; i++) imem[i] = rand_word();
        for (int i = 0; i < 5; i++) imem[i] = 32'(i + 1);

        rst                = 1'b1;
        bus.deq_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
`ifdef FETCH_PERF_EN
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_stall_rst",   perf_stall,   32'd0);
`endif
        rst = 1'b0;

        // Boot cycle, then 1..4 stream out back to back
        cyc(1, 0, 0);
        chk("boot_no_valid", 32'(bus.deq_valid), 32'd0);
        cyc(1, 0, 0);
        chk("first_word", bus.deq_inst, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            cyc(1, 0, 0);
            chk("stream_word", bus.deq_inst, 32'(k));
        end

        // Stall: restart at 0 and hold off dispatch for 8 cycles
        cyc(0, 1, 0);
        repeat (8) cyc(0, 0, 0);
        chk("stall_count", 32'(bus.count), 32'd4);
        chk("stall_addr",  32'(bus.imem_addr), 32'd4);
        for (int k = 1; k <= 5; k++) begin
            chk("drain_word", bus.deq_inst, 32'(k));
            cyc(1, 0, 0);
        end

        // Redirect to 0x100 with three entries queued
        cyc(0, 1, 0);
        for (int k = 0; k < 8 && q.size() != 3; k++) cyc(0, 0, 0);
        chk("reach_cnt3", 32'(bus.count), 32'd3);
        cyc(1, 1, 'h100);
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("redir_valid", 32'(bus.deq_valid), 32'd0);
        cyc(1, 0, 0);
        chk("redir_target", 32'(bus.deq_pc), 32'h100);

        // HALT opcode at address 5
        imem[5] = 32'hFC00_0000;
        cyc(1, 1, 0);
        repeat (12) cyc(1, 0, 0);
        chk("halt_flag",  32'(bus.halted), 32'd1);
        chk("halt_addr",  32'(bus.imem_addr), 32'd6);
        chk("halt_drain", 32'(bus.count), 32'd0);
        cyc(1, 1, 0);
        chk("halt_exit", 32'(bus.halted), 32'd0);
        cyc(1, 0, 0);
        chk("resume_pc", 32'(bus.deq_pc), 32'd0);

        // PC wrap at the top of the address space
        cyc(1, 1, 1022);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            chk("wrap_pc", 32'(bus.deq_pc), 32'((1022 + k) % MEMSZ));
        end

        // Random dispatch back-pressure and redirects
        for (int n = 0; n < 400; n++) begin
            bit rdy;
            bit rd;
            int tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 1022 : int'($urandom_range(0, MEMSZ - 1));
            cyc(rdy, rd, tgt);
        end

        // Asynchronous reset with two entries queued
        cyc(0, 1, 64);
        for (int k = 0; k < 8 && q.size() != 2; k++) cyc(0, 0, 0);
        chk("reach_cnt2", 32'(bus.count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
`ifdef FETCH_PERF_EN
        chk("perf_fetched_async", perf_fetched, 32'd0);
        chk("perf_stall_async",   perf_stall,   32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0);
        chk("post_rst_boot", 32'(bus.deq_valid), 32'd0);
        cyc(1, 0, 0);
        chk("post_rst_fetch", 32'(bus.deq_pc), 32'd0);
        repeat (4) cyc(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer and instruction buffer in front of the SSOOO decode/dispatch stage. Owns the program counter, drives the word-addressed instruction memory, and buffers fetched words in a small FIFO. Presents them to dispatch through a valid/ready handshake. Handles branch/jump redirects with a queue flush, and stops fetching at a HALT instruction.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 10: PC/instruction-memory word-address width (1024-word memory).
- START_PC, 0: PC loaded at reset.
- HALT_OP, 6'h3F: value of inst[31:26] that stops fetching.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset rst, asynchronous, active-high.
- imem_addr  out  ADDR_W  word address to instruction memory; equals the PC register.
- imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle.
- redirect_valid  in  1  branch/jump resolved taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  new fetch address.
- deq_valid  out  1  FIFO head valid.
- deq_ready  in  1  dispatch accepts the head this cycle.
- deq_inst  out  32  head instruction word.
- deq_pc  out  ADDR_W  address of the head instruction.
- count  out  log2(DEPTH)+1  current occupancy.
- halted  out  1  sequencer is in HALT.

## Operation
- States: BOOT, RUN, HALT.
- BOOT lasts one cycle after reset release, with no fetch, then moves to RUN.
- Reset values: PC=START_PC, state=BOOT, FIFO empty, count=0, deq_valid=0, halted=0. deq_inst and deq_pc read as 0 when the FIFO is empty.
- Fetch condition in RUN: `enq = (count<DEPTH) || (deq_valid && deq_ready)`.
- On enq, {imem_rdata, PC} is written at the tail and PC advances to PC+1. The PC wraps from 2^ADDR_W−1 to 0.
- A dequeue pops the head when `deq_valid && deq_ready`.
- Enqueue and dequeue in the same cycle leave count unchanged. This is allowed even when the FIFO is full.
- Halt: if an enqueued word has inst[31:26]==HALT_OP, it is enqueued normally and the state goes to HALT. PC holds at halt address+1. No further fetch. The queue keeps draining.
- Redirect (highest priority, any state):
  - FIFO cleared and count=0.
  - PC=redirect_pc.
  - State becomes RUN.
  - No enqueue that cycle; the imem_rdata word in that cycle is discarded.
  - A dequeue handshake in the redirect cycle still counts as accepted by dispatch; the FIFO is cleared regardless.
- A word with HALT_OP presented in a redirect cycle is ignored.
- Only redirect or rst leaves HALT.
- deq_valid is never high while count=0.

## Timing
- Fetch-to-dispatch latency: one cycle. A word fetched at edge N appears on deq_* after edge N and can be accepted at edge N+1 when the FIFO was empty.
- Sustained throughput: 1 instruction/cycle while deq_ready stays high.
- After redirect at edge N:
  - deq_valid=0 during cycle N+1.
  - The first target word is fetched at edge N+1.
  - That word is visible after edge N+1.
- Full FIFO with deq_ready=0: PC and imem_addr are held stable, and no word is lost.
- Async rst mid-operation: all state returns to reset values immediately. The first fetch occurs at the second posedge after rst deasserts.

## Configuration
- FETCH_PERF_EN defined: adds outputs `perf_fetched` (32-bit, increments on each enqueue) and `perf_stall` (32-bit, increments each RUN cycle where count==DEPTH and no dequeue).
  - Both reset to 0 on rst.
  - Neither changes on redirect.
  - Both wrap at 2^32.
- FETCH_PERF_EN not defined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (BOOT/RUN/HALT)
  - the HALT_OP default
  - the opcode-field bit positions [31:26]
- Sub-module `inst_fifo` is a synchronous FIFO of {inst, pc} entries. It has:
  - push/pop/clear inputs
  - a count output
  - a combinational head output
  - pointers one bit wider than log2(DEPTH) to separate full from empty
- `fetch_seq` holds the FSM, the PC and the redirect priority logic.

## Test plan
- Reset with START_PC=0 and imem[0..3]=1,2,3,4, deq_ready=1:
  - deq_valid=0 through BOOT;
  - deq_inst then reads 1,2,3,4 with deq_pc 0,1,2,3 on consecutive cycles.
- deq_ready=0 for 8 cycles:
  - count saturates at 4;
  - imem_addr holds at 4;
  - after release, words 1..4 then 5 arrive in order with no gaps or duplicates.
- Redirect to 0x100 while count=3:
  - next cycle count=0 and deq_valid=0;
  - following cycle deq_pc=0x100.
- imem[5]=0xFC000000 (HALT_OP):
  - halted=1 after word 5 is enqueued;
  - imem_addr stays at 6;
  - queue drains to 0;
  - a later redirect to 0 resumes fetching from address 0.
- Start at 1022 (redirect to 1022):
  - deq_pc sequence 1022, 1023, 0, 1.
- rst asserted mid-stream with count=2:
  - all outputs return to reset values immediately;
  - with FETCH_PERF_EN, perf_fetched=0 and perf_stall=0.
